// File: rtl/noncache_pkg.sv
// rtl/noncache_pkg.sv - shared types and encodings for the noncache bridge
package noncache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] EXPT_NONE  = 8'd0;
  localparam logic [7:0] EXPT_BUS   = 8'd1;
  localparam logic [7:0] EXPT_ALIGN = 8'd2;

  localparam logic [3:0] LEN_1B = 4'b0001;
  localparam logic [3:0] LEN_2B = 4'b0010;
  localparam logic [3:0] LEN_4B = 4'b0100;
  localparam logic [3:0] LEN_8B = 4'b1000;

endpackage

// File: rtl/nc_lane_align.sv
// rtl/nc_lane_align.sv - byte-lane strobes, write/read shifting and alignment check
module nc_lane_align
  import noncache_pkg::*;
(
  input  logic [2:0]  i_addr_lo,
  input  logic [3:0]  i_len,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_misalign,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shift;
  logic [31:0] w_rshift;

  assign w_shift  = {i_addr_lo[1:0], 3'b000};
  assign w_rshift = i_rdata >> w_shift;
  assign o_wdata  = i_wdata << w_shift;

  always_comb begin
    o_misalign = 1'b0;
    o_wstrb    = 4'b1111;
    o_rdata    = w_rshift;
    case (i_len)
      LEN_1B: begin
        o_wstrb = 4'b0001 << i_addr_lo[1:0];
        o_rdata = {24'd0, w_rshift[7:0]};
      end
      LEN_2B: begin
        o_misalign = i_addr_lo[0];
        o_wstrb    = 4'b0011 << i_addr_lo[1:0];
        o_rdata    = {16'd0, w_rshift[15:0]};
      end
      LEN_4B:  o_misalign = |i_addr_lo[1:0];
      LEN_8B:  o_misalign = |i_addr_lo;
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/noncache_bridge.sv
// rtl/noncache_bridge.sv - core noncache port to 32-bit peripheral bus bridge
// Optional wait-state timeout and stale-response drop: NONCACHE_TIMEOUT_EN.
module noncache_bridge
  import noncache_pkg::*;
#(
  parameter int ADDR_W         = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              noncache_req_vld,
  output logic              noncache_req_rdy,
  input  logic [ADDR_W-1:0] noncache_req_addr,
  input  logic [3:0]        noncache_req_len,
  input  logic              noncache_req_store,
  input  logic [63:0]       noncache_req_data,
  output logic              noncache_resp_vld,
  input  logic              noncache_resp_rdy,
  output logic [7:0]        noncache_resp_expt,
  output logic [63:0]       noncache_resp_data,
  output logic              bus_req_vld,
  input  logic              bus_req_rdy,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_write,
  output logic [3:0]        bus_req_wstrb,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_resp_vld,
  output logic              bus_resp_rdy,
  input  logic              bus_resp_err,
  input  logic [31:0]       bus_resp_rdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic              r_store;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic [7:0]        r_expt;
  logic              r_hi;

  logic              w_idle, w_issue, w_stale, w_tmo, w_misalign;
  logic [2:0]        w_al_addr;
  logic [3:0]        w_al_len, w_wstrb;
  logic [31:0]       w_beat_data, w_wdata, w_rdata;

  assign w_idle      = (r_state == S_IDLE);
  assign w_al_addr   = w_idle ? noncache_req_addr[2:0] : r_addr[2:0];
  assign w_al_len    = w_idle ? noncache_req_len : r_len;
  assign w_beat_data = r_hi ? r_wdata[63:32] : r_wdata[31:0];

  nc_lane_align u_align (
    .i_addr_lo  (w_al_addr),
    .i_len      (w_al_len),
    .i_wdata    (w_beat_data),
    .i_rdata    (bus_resp_rdata),
    .o_misalign (w_misalign),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );

  assign noncache_req_rdy   = w_idle;
  assign noncache_resp_vld  = (r_state == S_RESP);
  assign noncache_resp_expt = noncache_resp_vld ? r_expt : 8'd0;
  assign noncache_resp_data = noncache_resp_vld ? r_rdata : 64'd0;

  // Beats wait in ISSUE while a timed-out response may still be in flight.
  assign w_issue       = (r_state == S_ISSUE) && !w_stale;
  assign bus_req_vld   = w_issue;
  assign bus_req_addr  = w_issue ? {r_addr[ADDR_W-1:2] + (ADDR_W-2)'(r_hi), 2'b00} : '0;
  assign bus_req_write = w_issue && r_store;
  assign bus_req_wstrb = (w_issue && r_store) ? w_wstrb : 4'd0;
  assign bus_req_wdata = (w_issue && r_store) ? w_wdata : 32'd0;
  assign bus_resp_rdy  = (r_state == S_WAIT) || w_stale;

`ifdef NONCACHE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_stale;

  assign w_stale = r_stale;
  assign w_tmo   = (r_state == S_WAIT) && !bus_resp_vld &&
                   (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_stale   <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + CNT_W'(1) : '0;
      if (w_tmo)
        r_stale <= 1'b1;
      else if (r_stale && bus_resp_vld)
        r_stale <= 1'b0;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_stale      = 1'b0;
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= 4'd0;
      r_store <= 1'b0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_expt  <= EXPT_NONE;
      r_hi    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (noncache_req_vld) begin
          r_addr  <= noncache_req_addr;
          r_len   <= noncache_req_len;
          r_store <= noncache_req_store;
          r_wdata <= noncache_req_data;
          r_rdata <= 64'd0;
          r_hi    <= 1'b0;
          r_expt  <= w_misalign ? EXPT_ALIGN : EXPT_NONE;
          r_state <= w_misalign ? S_RESP : S_ISSUE;
        end
        S_ISSUE: if (w_issue && bus_req_rdy) r_state <= S_WAIT;
        S_WAIT: begin
          if (bus_resp_vld) begin
            if (bus_resp_err) begin
              r_expt  <= EXPT_BUS;
              r_rdata <= 64'd0;
              r_state <= S_RESP;
            end else begin
              if (!r_store) begin
                if (r_hi) r_rdata[63:32] <= w_rdata;
                else      r_rdata[31:0]  <= w_rdata;
              end
              if ((r_len == LEN_8B) && !r_hi) begin
                r_hi    <= 1'b1;
                r_state <= S_ISSUE;
              end else begin
                r_state <= S_RESP;
              end
            end
          end else if (w_tmo) begin
            r_expt  <= EXPT_BUS;
            r_rdata <= 64'd0;
            r_state <= S_RESP;
          end
        end
        S_RESP: if (noncache_resp_rdy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noncache_bridge.sv
// tb/tb_noncache_bridge.sv - self-checking bench for noncache_bridge
module tb_noncache_bridge;

  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          noncache_req_vld, noncache_req_rdy, noncache_req_store;
  logic [AW-1:0] noncache_req_addr;
  logic [3:0]    noncache_req_len;
  logic [63:0]   noncache_req_data;
  logic          noncache_resp_vld, noncache_resp_rdy;
  logic [7:0]    noncache_resp_expt;
  logic [63:0]   noncache_resp_data;
  logic          bus_req_vld, bus_req_rdy, bus_req_write;
  logic [AW-1:0] bus_req_addr;
  logic [3:0]    bus_req_wstrb;
  logic [31:0]   bus_req_wdata;
  logic          bus_resp_vld, bus_resp_rdy, bus_resp_err;
  logic [31:0]   bus_resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noncache_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .noncache_req_vld(noncache_req_vld), .noncache_req_rdy(noncache_req_rdy),
    .noncache_req_addr(noncache_req_addr), .noncache_req_len(noncache_req_len),
    .noncache_req_store(noncache_req_store), .noncache_req_data(noncache_req_data),
    .noncache_resp_vld(noncache_resp_vld), .noncache_resp_rdy(noncache_resp_rdy),
    .noncache_resp_expt(noncache_resp_expt), .noncache_resp_data(noncache_resp_data),
    .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy), .bus_req_addr(bus_req_addr),
    .bus_req_write(bus_req_write), .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
    .bus_resp_vld(bus_resp_vld), .bus_resp_rdy(bus_resp_rdy), .bus_resp_err(bus_resp_err),
    .bus_resp_rdata(bus_resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    noncache_req_vld = 1'b0; noncache_req_addr = '0; noncache_req_len = 4'd0;
    noncache_req_store = 1'b0; noncache_req_data = 64'd0; noncache_resp_rdy = 1'b0;
    bus_req_rdy = 1'b0; bus_resp_vld = 1'b0; bus_resp_err = 1'b0; bus_resp_rdata = 32'd0;
  endtask

  // Reference: one request expands to a list of expected beats and a single response.
  task automatic run_txn(input logic [47:0] addr, input logic [3:0] len, input bit store,
                         input logic [63:0] data_in, input int err_beat, input int hold,
                         input bit fast, input logic [31:0] rd0, input logic [31:0] rd1);
    int nb, off, exp_beats, issued, rbeat, delay, left, lat, k;
    bit legal, err, pend, done, got;
    logic [63:0] data, mask, exp_data, held_data;
    logic [7:0]  exp_expt, held_expt;
    logic [47:0] base;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;

    case (len)
      4'b0001: nb = 1;
      4'b0010: nb = 2;
      4'b0100: nb = 4;
      4'b1000: nb = 8;
      default: nb = 0;
    endcase
    legal = 1'b0;
    if (nb != 0) legal = ((int'(addr[2:0]) % nb) == 0);
    off  = int'(addr[1:0]);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    data = data_in & mask;
    base = addr - 48'(off);
    exp_beats = !legal ? 0 : ((nb == 8) ? 2 : 1);
    err = 1'b0;
    if (err_beat >= 0 && err_beat < exp_beats) begin
      err = 1'b1;
      exp_beats = err_beat + 1;
    end
    exp_expt = !legal ? 8'd2 : (err ? 8'd1 : 8'd0);
    if (!legal || err || store) exp_data = 64'd0;
    else if (nb == 8)           exp_data = {rd1, rd0};
    else                        exp_data = (64'(rd0) >> (8 * off)) & mask;

    @(negedge clk);
    chk("req_rdy_idle", 64'(noncache_req_rdy), 64'd1);
    noncache_req_vld = 1'b1; noncache_req_addr = addr; noncache_req_len = len;
    noncache_req_store = store; noncache_req_data = data;

    pend = 0; done = 0; got = 0; issued = 0; rbeat = 0; lat = 0; left = hold; delay = 0;
    held_data = 64'd0; held_expt = 8'd0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      noncache_req_vld = 1'b0; noncache_resp_rdy = 1'b0; bus_req_rdy = 1'b0;
      bus_resp_vld = 1'b0; bus_resp_err = 1'b0; bus_resp_rdata = 32'd0;
      if (pend) begin
        if (delay > 0) delay--;
        else if (bus_resp_rdy) begin
          bus_resp_vld   = 1'b1;
          bus_resp_err   = (rbeat == err_beat);
          bus_resp_rdata = (rbeat == 0) ? rd0 : rd1;
          pend = 0;
          rbeat++;
        end
      end
      if (bus_req_vld) begin
        k = (issued > 1) ? 1 : issued;
        exp_wstrb = !store ? 4'd0 : (nb >= 4) ? 4'hF : 4'(((1 << nb) - 1) << off);
        exp_wdata = !store ? 32'd0 : (nb == 8) ? ((k == 1) ? data[63:32] : data[31:0])
                                               : 32'(data << (8 * off));
        chk("beat_addr", 64'(bus_req_addr), 64'(base + 48'(4 * k)));
        chk("beat_write", 64'(bus_req_write), 64'(store));
        chk("beat_wstrb", 64'(bus_req_wstrb), 64'(exp_wstrb));
        chk("beat_wdata", 64'(bus_req_wdata), 64'(exp_wdata));
        if (fast || $urandom_range(0, 1) == 1) begin
          bus_req_rdy = 1'b1;
          issued++;
          pend  = 1;
          delay = fast ? 0 : $urandom_range(0, 2);
        end
      end
      if (noncache_resp_vld) begin
        if (!got) begin
          got = 1; lat = cyc;
          held_data = noncache_resp_data; held_expt = noncache_resp_expt;
          chk("resp_data", noncache_resp_data, exp_data);
          chk("resp_expt", 64'(noncache_resp_expt), 64'(exp_expt));
          chk("resp_vs_req_rdy", 64'(noncache_req_rdy), 64'd0);
        end else begin
          chk("resp_hold_data", noncache_resp_data, held_data);
          chk("resp_hold_expt", 64'(noncache_resp_expt), 64'(held_expt));
        end
        if (left > 0) left--;
        else begin
          noncache_resp_rdy = 1'b1;
          done = 1;
        end
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    chk("beat_count", 64'(issued), 64'(exp_beats));
    if (fast) chk("latency", 64'(lat), 64'(2 * exp_beats + 1));
    @(negedge clk);
    quiet_inputs();
    chk("idle_after_rdy", 64'(noncache_req_rdy), 64'd1);
    chk("resp_vld_after", 64'(noncache_resp_vld), 64'd0);
  endtask

  initial begin
    logic [47:0] a;
    logic [3:0]  l;
    logic [3:0]  lens [6];
    int          lat;
    bit          acc;

    lens = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b0000};
    rst = 1'b1;
    quiet_inputs();
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 64'(noncache_req_rdy), 64'd1);
    chk("rst_resp_vld", 64'(noncache_resp_vld), 64'd0);
    chk("rst_resp_expt", 64'(noncache_resp_expt), 64'd0);
    chk("rst_resp_data", noncache_resp_data, 64'd0);
    chk("rst_bus_vld", 64'(bus_req_vld), 64'd0);
    chk("rst_bus_addr", 64'(bus_req_addr), 64'd0);
    chk("rst_bus_wstrb", 64'(bus_req_wstrb), 64'd0);
    chk("rst_bus_wdata", 64'(bus_req_wdata), 64'd0);
    rst = 1'b0;

    run_txn(48'h0000_1000_0004, 4'b0100, 0, 64'd0, -1, 0, 1, 32'hDEADBEEF, 32'd0);
    run_txn(48'h0000_1000_0003, 4'b0001, 1, 64'hAB, -1, 0, 1, 32'd0, 32'd0);
    run_txn(48'h0000_1000_0008, 4'b1000, 0, 64'd0, -1, 0, 1, 32'h11111111, 32'h22222222);
    run_txn(48'h0000_1000_0002, 4'b0100, 0, 64'd0, -1, 0, 1, 32'd0, 32'd0);
    run_txn(48'h0000_1000_0010, 4'b0110, 0, 64'd0, -1, 0, 1, 32'd0, 32'd0);
    run_txn(48'h0000_1000_0004, 4'b1000, 0, 64'd0, -1, 0, 1, 32'd0, 32'd0);
    run_txn(48'h0000_1000_0020, 4'b1000, 1, 64'h0123_4567_89AB_CDEF, 0, 5, 1, 32'd0, 32'd0);
    run_txn(48'h0000_2000_0006, 4'b0010, 0, 64'd0, -1, 2, 1, 32'hCAFEF00D, 32'd0);
    run_txn(48'h0000_2000_0018, 4'b1000, 0, 64'd0, 1, 0, 1, 32'h5555AAAA, 32'h77778888);
    run_txn(48'h0000_2000_0002, 4'b0010, 1, 64'hFFFF_1234, -1, 0, 1, 32'd0, 32'd0);

    // Reset while a beat is outstanding, then a normal transfer.
    @(negedge clk);
    noncache_req_vld = 1'b1; noncache_req_addr = 48'h40; noncache_req_len = 4'b0100;
    noncache_req_store = 1'b1; noncache_req_data = 64'h1234_5678;
    @(negedge clk);
    noncache_req_vld = 1'b0;
    chk("mid_beat_vld", 64'(bus_req_vld), 64'd1);
    bus_req_rdy = 1'b1;
    @(negedge clk);
    bus_req_rdy = 1'b0;
    chk("mid_wait_rdy", 64'(bus_resp_rdy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_rdy", 64'(noncache_req_rdy), 64'd1);
    chk("mid_rst_resp_rdy", 64'(bus_resp_rdy), 64'd0);
    chk("mid_rst_bus_vld", 64'(bus_req_vld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_inputs();
    run_txn(48'h0000_3000_0001, 4'b0001, 0, 64'd0, -1, 0, 1, 32'hA1B2C3D4, 32'd0);

    for (int i = 0; i < 40; i++) begin
      l = lens[$urandom_range(0, 5)];
      a = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) != 0) begin
        case (l)
          4'b0010: a[0]   = 1'b0;
          4'b0100: a[1:0] = 2'b00;
          4'b1000: a[2:0] = 3'b000;
          default: ;
        endcase
      end
      run_txn(a, l, 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : -1,
              int'($urandom_range(0, 3)), 0, $urandom(), $urandom());
    end

`ifdef NONCACHE_TIMEOUT_EN
    // Silent bus: timeout after 16 WAIT cycles, then the late response is swallowed.
    @(negedge clk);
    noncache_req_vld = 1'b1; noncache_req_addr = 48'h100; noncache_req_len = 4'b0100;
    noncache_req_store = 1'b0;
    lat = 0; acc = 0;
    for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
      @(negedge clk);
      noncache_req_vld = 1'b0;
      bus_req_rdy = bus_req_vld && !acc;
      if (bus_req_vld) acc = 1;
      if (noncache_resp_vld) lat = cyc;
    end
    bus_req_rdy = 1'b0;
    chk("tmo_latency", 64'(lat), 64'd18);
    chk("tmo_expt", 64'(noncache_resp_expt), 64'd1);
    chk("tmo_data", noncache_resp_data, 64'd0);
    chk("tmo_stale_rdy", 64'(bus_resp_rdy), 64'd1);
    bus_resp_vld = 1'b1; bus_resp_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    bus_resp_vld = 1'b0; bus_resp_rdata = 32'd0;
    chk("tmo_resp_held", 64'(noncache_resp_vld), 64'd1);
    chk("tmo_stale_clr", 64'(bus_resp_rdy), 64'd0);
    noncache_resp_rdy = 1'b1;
    @(negedge clk);
    noncache_resp_rdy = 1'b0;
    run_txn(48'h0000_4000_0004, 4'b0100, 0, 64'd0, -1, 0, 1, 32'h600DF00D, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
